// File: rtl/serialboot_fifo.sv
// ASCII-hex UART loader: decodes hex words, buffers them in a small FIFO
// and writes them to PSRAM over a mem_we/mem_ready handshake.
module serialboot_fifo #(
    parameter int DATA_W     = 32,
    parameter int FIFO_DEPTH = 4,
    parameter bit LE_NIBBLES = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [2:0]        a,
    input  logic [31:0]       d,
    input  logic              we,
    output logic [31:0]       spo,
    output logic              ready,
    output logic              uart_override,
    input  logic [7:0]        uart_data,
    input  logic              uart_ready,
    output logic              mem_override,
    output logic [31:0]       mem_a,
    output logic [DATA_W-1:0] mem_d,
    output logic              mem_we,
    input  logic              mem_ready
);

    localparam int NIB   = DATA_W / 4;
    localparam int NCW   = $clog2(NIB);
    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int BYTES = DATA_W / 8;
    localparam int NSL   = (DATA_W + 31) / 32;

    typedef enum logic [1:0] {
        IDLE,
        RECV,
        DRAIN,
        DONE
    } state_t;

    state_t            state;
    logic [DATA_W-1:0] fifo_mem [FIFO_DEPTH];
    logic [AW:0]       rd_ptr;
    logic [AW:0]       wr_ptr;
    logic [NCW-1:0]    nib_cnt;
    logic [DATA_W-1:0] asm_q;
    logic [31:0]       addr;
    logic [31:0]       limit;
    logic [31:0]       words_written;
    logic [31:0]       words_pushed;
    logic [31:0]       checksum;
    logic [1:0]        err;

    logic              fifo_empty;
    logic              fifo_full;
    logic              busy;
    logic              rx;
    logic              is_dig;
    logic              is_space;
    logic [3:0]        dig;
    logic              last_nib;
    logic [DATA_W-1:0] full_word;
    logic [DATA_W-1:0] push_word;
    logic              push_req;
    logic              pop;
    logic              push_ok;
    logic              overflow;
    logic              hit_limit;
    logic [31:0]       head_sum;
    logic [NSL*32-1:0] head_pad;

    assign fifo_empty = (rd_ptr == wr_ptr);
    assign fifo_full  = (rd_ptr[AW-1:0] == wr_ptr[AW-1:0]) &&
                        (rd_ptr[AW] != wr_ptr[AW]);

    assign busy          = (state == RECV) || (state == DRAIN);
    assign ready         = !busy;
    assign uart_override = busy;
    assign mem_override  = busy;

    assign mem_we = busy && !fifo_empty;
    assign mem_d  = fifo_mem[rd_ptr[AW-1:0]];
    assign mem_a  = {2'b00, addr[31:2]};

    // Hex digit decode; only lowercase a-f is accepted.
    always_comb begin
        is_dig = 1'b0;
        dig    = 4'd0;
        if (uart_data >= 8'h30 && uart_data <= 8'h39) begin
            is_dig = 1'b1;
            dig    = uart_data[3:0];
        end else if (uart_data >= 8'h61 && uart_data <= 8'h66) begin
            is_dig = 1'b1;
            dig    = uart_data[3:0] + 4'd9;
        end
    end

    assign is_space  = (uart_data == 8'h20);
    assign rx        = (state == RECV) && uart_ready;
    assign last_nib  = (nib_cnt == NCW'(NIB - 1));
    assign full_word = {asm_q[DATA_W-5:0], dig};

    always_comb begin
        push_word = full_word;
        if (LE_NIBBLES) begin
            for (int i = 0; i < BYTES; i++)
                push_word[i*8 +: 8] = full_word[(BYTES-1-i)*8 +: 8];
        end
    end

    assign pop       = mem_we && mem_ready;
    assign push_req  = rx && is_dig && last_nib;
    assign push_ok   = push_req && (!fifo_full || pop);
    assign overflow  = push_req && fifo_full && !pop;
    assign hit_limit = (limit != 32'd0) &&
                       (words_pushed + 32'd1 == limit);

    // Wide words fold into the checksum as 32-bit slices.
    always_comb begin
        head_pad = (NSL*32)'(mem_d);
        head_sum = 32'd0;
        for (int i = 0; i < NSL; i++)
            head_sum = head_sum + head_pad[i*32 +: 32];
    end

    always_ff @(posedge clk) begin
        if (push_ok)
            fifo_mem[wr_ptr[AW-1:0]] <= push_word;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            rd_ptr        <= '0;
            wr_ptr        <= '0;
            nib_cnt       <= '0;
            asm_q         <= '0;
            addr          <= '0;
            limit         <= '0;
            words_written <= '0;
            words_pushed  <= '0;
            checksum      <= '0;
            err           <= 2'b00;
        end else begin
            if (pop) begin
                rd_ptr        <= rd_ptr + (AW+1)'(1);
                addr          <= addr + 32'(BYTES);
                words_written <= words_written + 32'd1;
                checksum      <= checksum + head_sum;
            end
            if (push_ok) begin
                wr_ptr       <= wr_ptr + (AW+1)'(1);
                words_pushed <= words_pushed + 32'd1;
            end
            if (rx && is_dig) begin
                asm_q   <= full_word;
                nib_cnt <= last_nib ? '0 : nib_cnt + NCW'(1);
            end

            unique case (state)
                RECV: begin
                    if (rx) begin
                        if (is_dig) begin
                            if (overflow) begin
                                err   <= 2'b11;
                                state <= DRAIN;
                            end else if (push_ok && hit_limit) begin
                                state <= DRAIN;
                            end
                        end else if (is_space) begin
                            if (nib_cnt != '0)
                                err <= 2'b10;
                            state <= DRAIN;
                        end else begin
                            err   <= 2'b01;
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (fifo_empty)
                        state <= DONE;
                end
                default: ;
            endcase

            if (we) begin
                unique case (a)
                    3'd1: addr  <= d;
                    3'd3: limit <= d;
                    3'd2: begin
                        if (state == IDLE || state == DONE) begin
                            err           <= 2'b00;
                            checksum      <= '0;
                            words_written <= '0;
                            words_pushed  <= '0;
                            nib_cnt       <= '0;
                            state         <= RECV;
                        end
                    end
                    3'd4: begin
                        state  <= IDLE;
                        rd_ptr <= '0;
                        wr_ptr <= '0;
                    end
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        spo = 32'd0;
        unique case (a)
            3'd0: spo = {27'd0, fifo_full, fifo_empty, err, state == DONE};
            3'd1: spo = addr;
            3'd3: spo = words_written;
            3'd5: spo = checksum;
            default: spo = 32'd0;
        endcase
    end

endmodule

// File: tb/tb_serialboot_fifo.sv
// Scoreboard bench for serialboot_fifo: directed UART streams, expected
// memory writes queued up front and checked by a per-DUT write monitor.
module tb_serialboot_fifo;

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst;
    always #5 clk = ~clk;

    logic [2:0]  a0, a1;
    logic [31:0] d0, d1;
    logic        we0, we1;
    logic [31:0] spo0, spo1;
    logic        ready0, ready1;
    logic        uo0, uo1;
    logic [7:0]  ud0, ud1;
    logic        ur0, ur1;
    logic        mo0, mo1;
    logic [31:0] ma0, ma1;
    logic [31:0] md0, md1;
    logic        mwe0, mwe1;
    logic        mr0, mr1;

    int checks = 0;
    int failures = 0;
    wr_t q0[$];
    wr_t q1[$];

    serialboot_fifo #(.DATA_W(32), .FIFO_DEPTH(4), .LE_NIBBLES(1'b0)) dut0 (
        .clk(clk), .rst(rst), .a(a0), .d(d0), .we(we0), .spo(spo0),
        .ready(ready0), .uart_override(uo0), .uart_data(ud0),
        .uart_ready(ur0), .mem_override(mo0), .mem_a(ma0), .mem_d(md0),
        .mem_we(mwe0), .mem_ready(mr0)
    );

    serialboot_fifo #(.DATA_W(32), .FIFO_DEPTH(4), .LE_NIBBLES(1'b1)) dut1 (
        .clk(clk), .rst(rst), .a(a1), .d(d1), .we(we1), .spo(spo1),
        .ready(ready1), .uart_override(uo1), .uart_data(ud1),
        .uart_ready(ur1), .mem_override(mo1), .mem_a(ma1), .mem_d(md1),
        .mem_we(mwe1), .mem_ready(mr1)
    );

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Write monitors: pop the scoreboard on every accepted write and
    // verify the request holds steady while mem_ready is low.
    logic        pw0 = 1'b0;
    logic [31:0] pa0, pd0;

    always @(negedge clk) begin
        if (pw0) begin
            chk("hold_we", {31'd0, mwe0}, 32'd1);
            chk("hold_a", ma0, pa0);
            chk("hold_d", md0, pd0);
        end
        pw0 = mwe0 && !mr0 && !rst && !(we0 && a0 == 3'd4);
        pa0 = ma0;
        pd0 = md0;
        if (mwe0 && mr0) begin
            if (q0.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL extra_write0: got %h@%h expected none",
                         md0, ma0);
            end else begin
                wr_t e;
                e = q0.pop_front();
                chk("wr0_a", ma0, e.a);
                chk("wr0_d", md0, e.d);
            end
        end
    end

    always @(negedge clk) begin
        if (mwe1 && mr1) begin
            if (q1.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL extra_write1: got %h@%h expected none",
                         md1, ma1);
            end else begin
                wr_t e;
                e = q1.pop_front();
                chk("wr1_a", ma1, e.a);
                chk("wr1_d", md1, e.d);
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic exp0(input logic [31:0] ea, input logic [31:0] ed);
        wr_t e;
        e.a = ea;
        e.d = ed;
        q0.push_back(e);
    endtask

    task automatic cpu_wr(input int u, input logic [2:0] ad,
                          input logic [31:0] dd);
        if (u == 0) begin
            a0 = ad; d0 = dd; we0 = 1'b1;
        end else begin
            a1 = ad; d1 = dd; we1 = 1'b1;
        end
        tick();
        we0 = 1'b0;
        we1 = 1'b0;
    endtask

    task automatic rd(input int u, input logic [2:0] ad,
                      input logic [31:0] exp, input string nm);
        if (u == 0) a0 = ad;
        else a1 = ad;
        #1;
        chk(nm, (u == 0) ? spo0 : spo1, exp);
    endtask

    task automatic send(input int u, input string s, input int gap);
        for (int i = 0; i < s.len(); i++) begin
            if (u == 0) begin
                ud0 = s[i]; ur0 = 1'b1;
            end else begin
                ud1 = s[i]; ur1 = 1'b1;
            end
            tick();
            ur0 = 1'b0;
            ur1 = 1'b0;
            repeat (gap) tick();
        end
    endtask

    task automatic wait_ready(input int u, input string nm);
        int n = 0;
        while (!((u == 0) ? ready0 : ready1) && n < 500) begin
            tick();
            n++;
        end
        chk(nm, {31'd0, (u == 0) ? ready0 : ready1}, 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        a0 = 3'd0; d0 = '0; we0 = 1'b0; ud0 = '0; ur0 = 1'b0; mr0 = 1'b1;
        a1 = 3'd0; d1 = '0; we1 = 1'b0; ud1 = '0; ur1 = 1'b0; mr1 = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        tick();

        // reset state
        rd(0, 3'd0, 32'h08, "rst_status");
        rd(0, 3'd1, 32'h0, "rst_addr");
        rd(0, 3'd3, 32'h0, "rst_words");
        rd(0, 3'd5, 32'h0, "rst_csum");
        chk("rst_ready", {31'd0, ready0}, 32'd1);
        chk("rst_uo", {31'd0, uo0}, 32'd0);
        chk("rst_mo", {31'd0, mo0}, 32'd0);
        chk("rst_we", {31'd0, mwe0}, 32'd0);

        // normal load
        cpu_wr(0, 3'd1, 32'h1000);
        cpu_wr(0, 3'd3, 32'd0);
        exp0(32'h400, 32'hdeadbeef);
        exp0(32'h401, 32'h01234567);
        cpu_wr(0, 3'd2, 32'd0);
        chk("recv_ready", {31'd0, ready0}, 32'd0);
        chk("recv_uo", {31'd0, uo0}, 32'd1);
        chk("recv_mo", {31'd0, mo0}, 32'd1);
        send(0, "deadbeef01234567 ", 1);
        wait_ready(0, "norm_done");
        rd(0, 3'd0, 32'h09, "norm_status");
        rd(0, 3'd5, 32'hdfd10456, "norm_csum");
        rd(0, 3'd3, 32'd2, "norm_words");
        rd(0, 3'd1, 32'h1008, "norm_addr");
        chk("norm_q", q0.size(), 32'd0);

        // backpressure and overflow
        mr0 = 1'b0;
        cpu_wr(0, 3'd1, 32'h0);
        exp0(32'h0, 32'h11111111);
        exp0(32'h1, 32'h22222222);
        exp0(32'h2, 32'h33333333);
        exp0(32'h3, 32'h44444444);
        cpu_wr(0, 3'd2, 32'd0);
        send(0, "1111111122222222333333334444444455555555", 2);
        rd(0, 3'd0, 32'h16, "ovf_status");
        chk("ovf_we", {31'd0, mwe0}, 32'd1);
        mr0 = 1'b1;
        wait_ready(0, "ovf_done");
        rd(0, 3'd0, 32'h0f, "ovf_status2");
        rd(0, 3'd3, 32'd4, "ovf_words");
        chk("ovf_q", q0.size(), 32'd0);

        // illegal character
        cpu_wr(0, 3'd1, 32'h2000);
        cpu_wr(0, 3'd2, 32'd0);
        send(0, "1234zz", 1);
        wait_ready(0, "ill_done");
        rd(0, 3'd0, 32'h0b, "ill_status");
        rd(0, 3'd3, 32'd0, "ill_words");

        // truncated word
        cpu_wr(0, 3'd1, 32'h3000);
        exp0(32'hc00, 32'h12345678);
        cpu_wr(0, 3'd2, 32'd0);
        send(0, "12345678abc ", 1);
        wait_ready(0, "trunc_done");
        rd(0, 3'd0, 32'h0d, "trunc_status");
        rd(0, 3'd3, 32'd1, "trunc_words");
        chk("trunc_q", q0.size(), 32'd0);

        // word limit
        cpu_wr(0, 3'd3, 32'd2);
        cpu_wr(0, 3'd1, 32'h4000);
        exp0(32'h1000, 32'h00000001);
        exp0(32'h1001, 32'h00000002);
        cpu_wr(0, 3'd2, 32'd0);
        send(0, "00000001000000020000000", 1);
        send(0, "99999999 ", 1);
        wait_ready(0, "lim_done");
        rd(0, 3'd0, 32'h09, "lim_status");
        rd(0, 3'd3, 32'd2, "lim_words");
        chk("lim_q", q0.size(), 32'd0);
        cpu_wr(0, 3'd3, 32'd0);

        // little-endian nibble order
        begin
            wr_t e;
            e.a = 32'h0;
            e.d = 32'h12345678;
            q1.push_back(e);
        end
        cpu_wr(1, 3'd1, 32'h0);
        cpu_wr(1, 3'd2, 32'd0);
        send(1, "78563412 ", 1);
        wait_ready(1, "le_done");
        rd(1, 3'd0, 32'h09, "le_status");
        chk("le_q", q1.size(), 32'd0);

        // abort mid-RECV with a buffered word
        mr0 = 1'b0;
        cpu_wr(0, 3'd1, 32'h7000);
        cpu_wr(0, 3'd2, 32'd0);
        send(0, "aaaaaaaa1234", 1);
        cpu_wr(0, 3'd4, 32'd0);
        chk("abort_uo", {31'd0, uo0}, 32'd0);
        chk("abort_mo", {31'd0, mo0}, 32'd0);
        chk("abort_ready", {31'd0, ready0}, 32'd1);
        chk("abort_we", {31'd0, mwe0}, 32'd0);
        rd(0, 3'd0, 32'h08, "abort_status");

        // reset mid-DRAIN, then restart from a reloaded address
        cpu_wr(0, 3'd1, 32'h5000);
        cpu_wr(0, 3'd2, 32'd0);
        send(0, "bbbbbbbb ", 1);
        rd(0, 3'd0, 32'h00, "drain_status");
        chk("drain_uo", {31'd0, uo0}, 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        rd(0, 3'd0, 32'h08, "rrst_status");
        rd(0, 3'd1, 32'h0, "rrst_addr");
        rd(0, 3'd3, 32'h0, "rrst_words");
        chk("rrst_ready", {31'd0, ready0}, 32'd1);
        mr0 = 1'b1;
        cpu_wr(0, 3'd1, 32'h6000);
        exp0(32'h1800, 32'hcafef00d);
        cpu_wr(0, 3'd2, 32'd0);
        send(0, "cafef00d ", 1);
        wait_ready(0, "new_done");
        rd(0, 3'd0, 32'h09, "new_status");
        rd(0, 3'd5, 32'hcafef00d, "new_csum");
        chk("new_q", q0.size(), 32'd0);

        repeat (3) tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
